// File: rtl/bus_arb_pkg.sv
// Shared definitions for the system-bus arbiter and the transceiver-side blocks
// that reuse its state and direction encodings.
package bus_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TURN  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  localparam logic DIR_A2B = 1'b1;
  localparam logic DIR_B2A = 1'b0;

  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_TURN  = ST_TURN,
    S_GRANT = ST_GRANT
  } arb_state_e;

  // Maps a requester's direction bit onto the transceiver DIR encoding.
  function automatic logic dir_from_req(input logic d);
    return d ? DIR_A2B : DIR_B2A;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and transceiver-control bundle between the requesters and the arbiter.
interface bus_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] dir_req;
  logic [N_REQ-1:0] grant;
  logic             OE_n;
  logic             DIR;
  logic             busy;

  modport master (
    output req, dir_req,
    input  grant, OE_n, DIR, busy
  );

  modport slave (
    input  req, dir_req,
    output grant, OE_n, DIR, busy
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first candidate at or after the pointer,
// wrapping at N_REQ, with an optional exclusion mask.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N_REQ-1:0] excl_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             valid_o
);

  logic [N_REQ-1:0] cand_s;

  assign cand_s = req_i & ~excl_i;

  // Scan from the pointer and keep the first eligible requester.
  always_comb begin : pick
    int               sum;
    logic [IDX_W-1:0] idx;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = int'(ptr_i) + i;
      if (sum >= N_REQ) begin
        sum = sum - N_REQ;
      end else begin
        sum = sum;
      end
      idx = IDX_W'(sum);
      if (!valid_o && cand_s[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared 8-bit bus; every owner or direction change
// passes through one TURN cycle with the transceiver disabled.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);

  localparam int                 IDX_W      = $clog2(N_REQ);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [N_REQ-1:0]   ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               dir_q, dir_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               oe_n_q, oe_n_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   excl_s;
  logic [N_REQ-1:0]   win_oh_s;
  logic               win_vld_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               rotate_s;

  // While owning the bus the owner is never its own successor.
  assign excl_s = (state_q == S_GRANT) ? (ONE_HOT0 << owner_q) : '0;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .excl_i   (excl_s),
    .winner_o (win_oh_s),
    .valid_o  (win_vld_s)
  );

  // One-hot winner to index.
  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh_s[i]) begin
        win_idx_s = IDX_W'(i);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  assign rotate_s = !bus.req[owner_q] || ((burst_q == BURST_LAST) && win_vld_s);

  // Next state, owner, direction, pointer, burst count and registered-output values.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld_s) begin
          state_d = S_TURN;
          owner_d = win_idx_s;
          dir_d   = dir_from_req(bus.dir_req[win_idx_s]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        state_d = S_GRANT;
        burst_d = '0;
        ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
      end
      S_GRANT: begin
        if (rotate_s) begin
          if (win_vld_s) begin
            state_d = S_TURN;
            owner_d = win_idx_s;
            dir_d   = dir_from_req(bus.dir_req[win_idx_s]);
          end else begin
            state_d = S_IDLE;
          end
        end else if (dir_from_req(bus.dir_req[owner_q]) != dir_q) begin
          state_d = S_TURN;
          dir_d   = dir_from_req(bus.dir_req[owner_q]);
        end else if (burst_q != BURST_LAST) begin
          burst_d = burst_q + BURST_W'(1);
        end else begin
          burst_d = burst_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    grant_d = (state_d == S_GRANT) ? (ONE_HOT0 << owner_d) : '0;
    oe_n_d  = (state_d != S_GRANT);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset drops the grant immediately without a turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      dir_q   <= DIR_B2A;
      burst_q <= '0;
      grant_q <= '0;
      oe_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      burst_q <= burst_d;
      grant_q <= grant_d;
      oe_n_q  <= oe_n_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.OE_n  = oe_n_q;
  assign bus.DIR   = dir_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int MB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bus_arbiter_if #(.N_REQ(N)) bus ();

  bus_arbiter #(
    .N_REQ     (N),
    .MAX_BURST (MB)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the bus, for how many cycles, and whose turn is next.
  typedef struct {
    bit   turn;
    bit   owned;
    int   owner;
    int   ptr;
    int   cnt;
    logic dir;
    bit   live;
  } mdl_t;

  mdl_t m = '{turn: 1'b0, owned: 1'b0, owner: 0, ptr: 0, cnt: 0, dir: 1'b0, live: 1'b0};

  function automatic int first_from(input logic [3:0] r, input int p, input int excl);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (p + i) % N;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  function automatic mdl_t model_step(input mdl_t cur, input logic [3:0] r,
                                      input logic [3:0] d, input logic rs);
    mdl_t nx;
    int   w;
    nx      = cur;
    nx.live = 1'b1;
    if (rs) begin
      nx.turn = 1'b0; nx.owned = 1'b0; nx.owner = 0; nx.ptr = 0; nx.cnt = 0; nx.dir = 1'b0;
    end else if (cur.turn) begin
      nx.turn = 1'b0; nx.owned = 1'b1; nx.cnt = 1; nx.ptr = (cur.owner + 1) % N;
    end else if (!cur.owned) begin
      w = first_from(r, cur.ptr, -1);
      if (w >= 0) begin
        nx.turn = 1'b1; nx.owner = w; nx.dir = d[w];
      end
    end else if (!r[cur.owner] || (cur.cnt >= MB && first_from(r, cur.ptr, cur.owner) >= 0)) begin
      w = first_from(r, cur.ptr, cur.owner);
      nx.owned = 1'b0;
      if (w >= 0) begin
        nx.turn = 1'b1; nx.owner = w; nx.dir = d[w];
      end
    end else if (d[cur.owner] !== cur.dir) begin
      nx.owned = 1'b0; nx.turn = 1'b1; nx.dir = d[cur.owner];
    end else begin
      nx.cnt = cur.cnt + 1;
    end
    return nx;
  endfunction

  always @(posedge clk) begin
    m <= model_step(m, bus.req, bus.dir_req, rst);
  end

  // Per-cycle comparison against the model plus transceiver-safety properties.
  logic       prev_valid = 1'b0;
  logic       prev_oe_n  = 1'b1;
  logic       prev_dir   = 1'b0;
  logic       prev_busy  = 1'b0;
  logic [3:0] prev_grant = 4'b0000;

  always @(negedge clk) begin
    logic [3:0] eg;
    if (m.live) begin
      eg = m.owned ? (4'b0001 << m.owner) : 4'b0000;
      chk("grant", {28'd0, bus.grant}, {28'd0, eg});
      chk("oe_n", {31'd0, bus.OE_n}, {31'd0, !m.owned});
      chk("dir", {31'd0, bus.DIR}, {31'd0, m.dir});
      chk("busy", {31'd0, bus.busy}, {31'd0, (m.turn || m.owned)});
      if (prev_valid && (bus.DIR !== prev_dir)) begin
        chk("dir_change_needs_oe_off", {31'd0, bus.OE_n}, 32'd1);
      end
      if (prev_valid && prev_oe_n && !bus.OE_n) begin
        chk("oe_fall_after_turn", {27'd0, prev_busy, prev_grant}, {27'd0, 1'b1, 4'b0000});
      end
    end
    prev_valid <= m.live;
    prev_oe_n  <= bus.OE_n;
    prev_dir   <= bus.DIR;
    prev_busy  <= bus.busy;
    prev_grant <= bus.grant;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [3:0] r_v;
  logic [3:0] d_v;
  logic [3:0] rr_exp [14];

  initial begin
    bus.req     = 4'b0000;
    bus.dir_req = 4'b0000;

    // Reset state, then a single requester A-to-B.
    rst = 1'b1;
    step();
    step();
    chk("rst_grant", {28'd0, bus.grant}, 32'd0);
    chk("rst_oe_n", {31'd0, bus.OE_n}, 32'd1);
    chk("rst_dir", {31'd0, bus.DIR}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    bus.req     = 4'b0010;
    bus.dir_req = 4'b0010;
    step();
    chk("t1_turn_grant", {28'd0, bus.grant}, 32'd0);
    chk("t1_turn_oe_n", {31'd0, bus.OE_n}, 32'd1);
    chk("t1_turn_dir", {31'd0, bus.DIR}, 32'd1);
    step();
    chk("t1_grant", {28'd0, bus.grant}, 32'h2);
    chk("t1_oe_n", {31'd0, bus.OE_n}, 32'd0);
    step();
    bus.req = 4'b0000;
    step();
    chk("t1_rel_grant", {28'd0, bus.grant}, 32'd0);
    chk("t1_rel_oe_n", {31'd0, bus.OE_n}, 32'd1);
    chk("t1_rel_busy", {31'd0, bus.busy}, 32'd0);

    // Round-robin with everyone requesting, two-cycle bursts.
    do_reset();
    rr_exp = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
    bus.req     = 4'b1111;
    bus.dir_req = 4'b0000;
    for (int k = 0; k < 14; k++) begin
      step();
      chk("rr_grant", {28'd0, bus.grant}, {28'd0, rr_exp[k]});
      chk("rr_oe_n", {31'd0, bus.OE_n}, {31'd0, (rr_exp[k] == 4'h0)});
    end

    // Direction flip by the owner.
    bus.req = 4'b0000;
    do_reset();
    bus.req     = 4'b0100;
    bus.dir_req = 4'b0000;
    step();
    step();
    chk("flip_grant0", {28'd0, bus.grant}, 32'h4);
    chk("flip_dir0", {31'd0, bus.DIR}, 32'd0);
    bus.dir_req = 4'b0100;
    step();
    chk("flip_turn_oe_n", {31'd0, bus.OE_n}, 32'd1);
    chk("flip_turn_dir", {31'd0, bus.DIR}, 32'd1);
    chk("flip_turn_grant", {28'd0, bus.grant}, 32'd0);
    step();
    chk("flip_grant1", {28'd0, bus.grant}, 32'h4);
    chk("flip_oe_n1", {31'd0, bus.OE_n}, 32'd0);

    // Release at the burst limit while requester 3 waits.
    bus.req = 4'b0000;
    do_reset();
    bus.req     = 4'b0001;
    bus.dir_req = 4'b0000;
    step();
    step();
    step();
    chk("sim_at_limit", {28'd0, bus.grant}, 32'h1);
    bus.req = 4'b1000;
    step();
    chk("sim_turn_grant", {28'd0, bus.grant}, 32'd0);
    chk("sim_turn_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("sim_grant3", {28'd0, bus.grant}, 32'h8);

    // Lone requester keeps the bus past the burst limit.
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b0001;
    step();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("lone_grant", {28'd0, bus.grant}, 32'h1);
      chk("lone_oe_n", {31'd0, bus.OE_n}, 32'd0);
    end

    // Reset while requester 2 owns the bus A-to-B.
    bus.req = 4'b0000;
    do_reset();
    bus.req     = 4'b0100;
    bus.dir_req = 4'b0100;
    step();
    step();
    chk("mid_grant", {28'd0, bus.grant}, 32'h4);
    rst = 1'b1;
    step();
    chk("mid_rst_grant", {28'd0, bus.grant}, 32'd0);
    chk("mid_rst_oe_n", {31'd0, bus.OE_n}, 32'd1);
    chk("mid_rst_dir", {31'd0, bus.DIR}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    bus.req     = 4'b1010;
    bus.dir_req = 4'b0000;
    step();
    step();
    chk("mid_ptr_zero", {28'd0, bus.grant}, 32'h2);

    // Randomized traffic: level requests toggling, direction flips, rare resets.
    r_v = 4'b0000;
    d_v = 4'b0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) r_v[i] = ~r_v[i];
      end
      if ($urandom_range(0, 11) == 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        d_v[k] = ~d_v[k];
      end
      rst         = ($urandom_range(0, 249) == 0);
      bus.req     = r_v;
      bus.dir_req = d_v;
      step();
    end
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
